// File: rtl/spi_slave_byte.sv
// ---------------------------------------------------------------------------
// spi_slave_byte
//
// SPI mode 0 (CPOL=0, CPHA=0) slave byte engine. The SPI pins are brought
// into the clk domain through flop synchronizers. MOSI bits are assembled
// MSB first into bytes and presented on byte_recv with a one-cycle valid
// pulse. Bytes written through write/byte_send wait in a one-deep holding
// register and are shifted out on MISO, MSB first, starting at the next byte
// boundary.
//
// Parameters
//   SYNC_STAGES  synchronizer depth on sclk/cs_n/mosi (2 or more)
//   IDLE_BYTE    byte sent on MISO when nothing is waiting in the holding reg
//
// Ports
//   clk         system clock, at least 8x the SCLK frequency
//   rst         synchronous active-high reset
//   sclk        SPI clock from the master (asynchronous)
//   cs_n        SPI chip select, active low (asynchronous)
//   mosi        SPI data from the master (asynchronous)
//   miso        SPI data to the master
//   miso_oe     MISO output enable, high while synchronized cs_n is low
//   byte_recv   last complete received byte, held until the next one
//   valid       one-cycle pulse when byte_recv has just been updated
//   write       one-cycle request to queue byte_send for transmission
//   byte_send   transmit byte, taken when write=1 and busy=0
//   busy        holding register full; write is not accepted
//   tx_overrun  one-cycle pulse: write arrived while busy (byte dropped)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module spi_slave_byte #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic [7:0] byte_recv,
  output logic       valid,
  input  logic       write,
  input  logic [7:0] byte_send,
  output logic       busy,
  output logic       tx_overrun
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   cs_d;

  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;

  logic                   rise;
  logic                   fall;
  logic                   sel;
  logic                   desel;

  logic [2:0]             bit_cnt;
  logic [7:0]             rx_shift;
  logic [7:0]             tx_shift;
  logic [7:0]             hold;
  logic                   hold_full;

  // Synchronizer chains plus one history flop for sclk and cs_n. cs_n
  // resets to the deselected level so reset never fakes a selection edge
  // while the pin is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // SCLK edges only count while the slave is selected.
  assign rise  =  sclk_s & ~sclk_d & ~cs_s;
  assign fall  = ~sclk_s &  sclk_d & ~cs_s;
  assign sel   = ~cs_s &  cs_d;
  assign desel =  cs_s & ~cs_d;

  // Receive shifter, transmit shifter and holding register. Accepting a
  // write (needs hold empty) and moving hold into the shifter (needs hold
  // full) can never happen in the same cycle, so a write that coincides
  // with the transfer is still seen as busy and reported as an overrun.
  // A frame boundary is the falling edge that follows the 8th rising edge,
  // which is exactly when bit_cnt has wrapped back to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= 3'd0;
      rx_shift   <= 8'h00;
      tx_shift   <= IDLE_BYTE;
      hold       <= 8'h00;
      hold_full  <= 1'b0;
      byte_recv  <= 8'h00;
      valid      <= 1'b0;
      tx_overrun <= 1'b0;
    end else begin
      valid      <= 1'b0;
      tx_overrun <= write & hold_full;

      if (write && !hold_full) begin
        hold      <= byte_send;
        hold_full <= 1'b1;
      end

      if (desel) begin
        bit_cnt  <= 3'd0;
        rx_shift <= 8'h00;
        tx_shift <= IDLE_BYTE;
      end else begin
        if (rise) begin
          rx_shift <= {rx_shift[6:0], mosi_s};
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_recv <= {rx_shift[6:0], mosi_s};
            valid     <= 1'b1;
          end
        end

        if (sel || (fall && bit_cnt == 3'd0)) begin
          tx_shift <= hold_full ? hold : IDLE_BYTE;
          if (hold_full) begin
            hold_full <= 1'b0;
          end
        end else if (fall) begin
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
      end
    end
  end

  assign miso    = tx_shift[7];
  assign miso_oe = ~cs_s;
  assign busy    = hold_full;

endmodule

// File: tb/tb_spi_slave_byte.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_byte
//
// Directed bench for spi_slave_byte. A mode-0 SPI master is modelled with
// timed pin wiggles on sclk/cs_n/mosi (SCLK period 160 ns, clk period
// 10 ns). Single-byte frames come from a vector table; multi-byte frames,
// write overrun, aborted frames and mid-byte reset are hand-written
// sequences.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_spi_slave_byte;

  localparam time HALF = 80ns;

  logic       clk;
  logic       rst;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [7:0] byte_recv;
  logic       valid;
  logic       write;
  logic [7:0] byte_send;
  logic       busy;
  logic       tx_overrun;

  int checks = 0;
  int errors = 0;

  // Pulse monitor state, written only by the monitor process below.
  int         validTotal   = 0;
  int         overrunTotal = 0;
  int         validWide    = 0;
  logic       prevValid    = 1'b0;
  logic [7:0] validLog[$];

  typedef struct {
    logic [7:0] mosiByte;
    bit         preWrite;
    logic [7:0] sendByte;
    logic [7:0] expMiso;
  } vec_t;

  vec_t vecs[5];

  spi_slave_byte #(
    .SYNC_STAGES(2),
    .IDLE_BYTE  (8'h00)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .byte_recv (byte_recv),
    .valid     (valid),
    .write     (write),
    .byte_send (byte_send),
    .busy      (busy),
    .tx_overrun(tx_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count valid/tx_overrun pulses on the falling clock edge and log every
  // received byte; also flag any valid that stays high two cycles running.
  always @(negedge clk) begin
    if (valid) begin
      validTotal = validTotal + 1;
      validLog.push_back(byte_recv);
      if (prevValid) validWide = validWide + 1;
    end
    if (tx_overrun) overrunTotal = overrunTotal + 1;
    prevValid = valid;
  end

  initial begin
    #500us;
    $display("[TB] FAIL watchdog expired before the test finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks = checks + 1;
    if (actual !== required) begin
      errors = errors + 1;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic doWrite(input logic [7:0] b);
    @(negedge clk);
    write     = 1'b1;
    byte_send = b;
    @(negedge clk);
    write     = 1'b0;
  endtask

  // Mode-0 master: drive MOSI while SCLK is low, sample MISO on the rise.
  task automatic spiBits(input logic [7:0] tx, input int n,
                         output logic [7:0] rx);
    rx = 8'h00;
    for (int k = 0; k < n; k++) begin
      mosi = tx[7-k];
      #HALF;
      sclk = 1'b1;
      rx   = {rx[6:0], miso};
      #HALF;
      sclk = 1'b0;
    end
  endtask

  task automatic csLow();
    cs_n = 1'b0;
    #HALF;
  endtask

  task automatic csHigh();
    #HALF;
    cs_n = 1'b1;
    #HALF;
    settle();
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int         base;
    logic [7:0] rx;
    if (v.preWrite) begin
      doWrite(v.sendByte);
      checkOutput($sformatf("vec%0d_busy_pre", idx), {31'd0, busy}, 32'd1);
    end
    base = validTotal;
    csLow();
    spiBits(v.mosiByte, 8, rx);
    csHigh();
    checkOutput($sformatf("vec%0d_valid_count", idx), validTotal - base, 32'd1);
    checkOutput($sformatf("vec%0d_byte_recv", idx), {24'd0, byte_recv},
                {24'd0, v.mosiByte});
    checkOutput($sformatf("vec%0d_miso_byte", idx), {24'd0, rx},
                {24'd0, v.expMiso});
    checkOutput($sformatf("vec%0d_busy_post", idx), {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int         base;
    int         ovBase;
    logic [7:0] rx1;
    logic [7:0] rx2;
    logic [7:0] rx3;

    vecs[0] = '{mosiByte: 8'hA5, preWrite: 1'b0, sendByte: 8'h00, expMiso: 8'h00};
    vecs[1] = '{mosiByte: 8'h5A, preWrite: 1'b1, sendByte: 8'h96, expMiso: 8'h96};
    vecs[2] = '{mosiByte: 8'h00, preWrite: 1'b1, sendByte: 8'hFF, expMiso: 8'hFF};
    vecs[3] = '{mosiByte: 8'hFF, preWrite: 1'b0, sendByte: 8'h00, expMiso: 8'h00};
    vecs[4] = '{mosiByte: 8'h81, preWrite: 1'b1, sendByte: 8'h7E, expMiso: 8'h7E};

    rst       = 1'b1;
    sclk      = 1'b0;
    cs_n      = 1'b1;
    mosi      = 1'b0;
    write     = 1'b0;
    byte_send = 8'h00;

    // Reset state.
    repeat (4) @(negedge clk);
    checkOutput("reset_miso",       {31'd0, miso},       32'd0);
    checkOutput("reset_miso_oe",    {31'd0, miso_oe},    32'd0);
    checkOutput("reset_byte_recv",  {24'd0, byte_recv},  32'd0);
    checkOutput("reset_valid",      {31'd0, valid},      32'd0);
    checkOutput("reset_busy",       {31'd0, busy},       32'd0);
    checkOutput("reset_tx_overrun", {31'd0, tx_overrun}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single-byte frames from the table.
    for (int i = 0; i < 5; i++) applyStimulus(vecs[i], i);

    // Byte queued before selection goes out first, then idle.
    doWrite(8'h3C);
    checkOutput("two_busy_pre", {31'd0, busy}, 32'd1);
    base = validTotal;
    csLow();
    checkOutput("two_busy_after_sel", {31'd0, busy}, 32'd0);
    checkOutput("two_miso_oe", {31'd0, miso_oe}, 32'd1);
    spiBits(8'h12, 8, rx1);
    spiBits(8'h34, 8, rx2);
    csHigh();
    checkOutput("two_valid_count", validTotal - base, 32'd2);
    checkOutput("two_recv0", {24'd0, validLog[base]},   32'h12);
    checkOutput("two_recv1", {24'd0, validLog[base+1]}, 32'h34);
    checkOutput("two_miso0", {24'd0, rx1}, 32'h3C);
    checkOutput("two_miso1", {24'd0, rx2}, 32'h00);

    // Write during byte 1 lands in byte 2.
    base = validTotal;
    csLow();
    doWrite(8'hC3);
    checkOutput("three_busy_after_write", {31'd0, busy}, 32'd1);
    spiBits(8'h01, 8, rx1);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("three_busy_after_boundary", {31'd0, busy}, 32'd0);
    spiBits(8'h04, 8, rx2);
    spiBits(8'h00, 8, rx3);
    csHigh();
    checkOutput("three_valid_count", validTotal - base, 32'd3);
    checkOutput("three_recv0", {24'd0, validLog[base]},   32'h01);
    checkOutput("three_recv1", {24'd0, validLog[base+1]}, 32'h04);
    checkOutput("three_recv2", {24'd0, validLog[base+2]}, 32'h00);
    checkOutput("three_miso0", {24'd0, rx1}, 32'h00);
    checkOutput("three_miso1", {24'd0, rx2}, 32'hC3);
    checkOutput("three_miso2", {24'd0, rx3}, 32'h00);

    // Back-to-back writes: second is dropped with a single overrun pulse.
    ovBase = overrunTotal;
    @(negedge clk);
    write     = 1'b1;
    byte_send = 8'h11;
    @(negedge clk);
    byte_send = 8'h22;
    @(negedge clk);
    write     = 1'b0;
    settle();
    checkOutput("ovr_pulse_count", overrunTotal - ovBase, 32'd1);
    checkOutput("ovr_busy", {31'd0, busy}, 32'd1);
    csLow();
    spiBits(8'h55, 8, rx1);
    csHigh();
    checkOutput("ovr_miso", {24'd0, rx1}, 32'h11);
    checkOutput("ovr_busy_post", {31'd0, busy}, 32'd0);

    // Aborted frame after 5 bits, then a clean byte.
    base = validTotal;
    csLow();
    spiBits(8'hF0, 5, rx1);
    csHigh();
    checkOutput("abort_no_valid", validTotal - base, 32'd0);
    csLow();
    spiBits(8'h7E, 8, rx1);
    csHigh();
    checkOutput("abort_next_valid", validTotal - base, 32'd1);
    checkOutput("abort_next_byte", {24'd0, byte_recv}, 32'h7E);

    // Reset in the middle of a byte with a byte pending.
    doWrite(8'h99);
    base = validTotal;
    csLow();
    spiBits(8'hA0, 4, rx1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_mid_busy",       {31'd0, busy},       32'd0);
    checkOutput("rst_mid_valid",      {31'd0, valid},      32'd0);
    checkOutput("rst_mid_byte_recv",  {24'd0, byte_recv},  32'd0);
    checkOutput("rst_mid_miso",       {31'd0, miso},       32'd0);
    checkOutput("rst_mid_miso_oe",    {31'd0, miso_oe},    32'd0);
    checkOutput("rst_mid_tx_overrun", {31'd0, tx_overrun}, 32'd0);
    csHigh();
    checkOutput("rst_mid_no_valid", validTotal - base, 32'd0);
    csLow();
    spiBits(8'hFF, 8, rx1);
    csHigh();
    checkOutput("rst_next_valid", validTotal - base, 32'd1);
    checkOutput("rst_next_byte", {24'd0, byte_recv}, 32'hFF);
    checkOutput("rst_next_miso", {24'd0, rx1}, 32'h00);

    checkOutput("valid_width", validWide, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
